case_1_acc_stream: RTL and testbench
====================================

CASE_1_ACC_STREAM -- requirements
Module: case_1_acc_stream

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 2: width of the signed product consumed from the upstream 2s x 2s multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 8: width of the signed accumulator and result.
REQ-003 SHALL have parameter LEN, default 16, legal range 2..255: number of products summed per result.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named ap_clk and ap_rst as elsewhere in the codebase.
REQ-005 ap_clk  input  1  clock; all state updates on the rising edge.
REQ-006 ap_rst  input  1  asynchronous active-high reset.
REQ-007 din  input  DIN_WIDTH  signed product from the multiplier.
REQ-008 din_vld  input  1  din is valid this cycle.
REQ-009 din_rdy  output  1  block accepts din this cycle.
REQ-010 dout  output  ACC_WIDTH  signed sum of LEN products.
REQ-011 dout_vld  output  1  dout holds a completed sum.
REQ-012 dout_rdy  input  1  downstream accepts dout.
REQ-013 dout_ovf  output  1  sticky flag: the accumulation for the current dout wrapped; qualified by dout_vld.

Function
REQ-014 SHALL implement FSM states S_ACC (collecting) and S_OUT (presenting the result).
REQ-015 In S_ACC, din_rdy SHALL be 1; in S_OUT, din_rdy SHALL be 0 and dout_vld SHALL be 1.
REQ-016 An input beat SHALL transfer when din_vld and din_rdy are both 1 in the same cycle; there is no other acceptance path.
REQ-017 Each beat SHALL add sign-extended din to the accumulator, with two's-complement wrap at ACC_WIDTH.
REQ-018 dout_ovf SHALL be set when a signed add overflows (operand signs equal and result sign differs), and SHALL stay set until the result is consumed.
REQ-019 A sample counter SHALL increment per beat. On the LEN-th beat, the FSM SHALL move to S_OUT in the next cycle, with dout equal to the full sum including that beat.
REQ-020 Latency: dout_vld SHALL rise exactly one cycle after the cycle that accepts the LEN-th beat.
REQ-021 In S_OUT, dout and dout_ovf SHALL hold stable until dout_rdy is 1.
REQ-022 On dout_vld and dout_rdy both 1, the next state SHALL be S_ACC, with accumulator, counter and dout_ovf cleared.
REQ-023 din_rdy SHALL stay 0 during the handshake cycle, so the first beat of the next group can be accepted at the earliest one cycle later.
REQ-024 din_vld gaps in S_ACC SHALL NOT change the accumulator or the counter.
REQ-025 dout_rdy while in S_ACC SHALL be ignored.
REQ-026 din_vld while in S_OUT SHALL be ignored; upstream must hold the data.

Reset
REQ-027 ap_rst SHALL asynchronously force the S_ACC state and clear the accumulator, counter, dout (0), dout_vld (0) and dout_ovf (0); din_rdy SHALL be 1 after reset.
REQ-028 Reset asserted mid-group or in S_OUT SHALL discard the partial sum or pending result; no dout_vld SHALL follow for that group.
REQ-029 Deassertion SHALL take effect at an ap_clk edge; the first beat SHALL be accepted on the first rising edge with ap_rst low.

Structure
REQ-030 The FSM state enum, the default DIN_WIDTH, ACC_WIDTH and LEN constants, and the counter width ($clog2(LEN+1)) SHALL live in shared package case_1_acc_pkg.
REQ-031 No sub-module SHALL be instantiated; case_1_mul_2s_2s_2_1_1 remains a separate upstream instance connected at the parent level.

Verification
REQ-032 Bench SHALL drive 16 back-to-back beats of din=1 with dout_rdy=1, and check dout=16, dout_ovf=0, dout_vld high for exactly one cycle, 1 cycle after the 16th beat.
REQ-033 Bench SHALL drive 16 beats of din=-2 (2'b10), and check dout=-32 (8'hE0) with dout_ovf=0.
REQ-034 Bench SHALL use LEN=4, ACC_WIDTH=2 with beats 1,1,0,0, and check that the wrap gives dout=-2 with dout_ovf=1; the next group of all-zero beats SHALL give dout=0, dout_ovf=0.
REQ-035 Bench SHALL hold dout_rdy=0 for 5 cycles in S_OUT with din_vld=1, and check that dout stays stable, din_rdy=0, and no beats are absorbed; the next group sum SHALL exclude the held data.
REQ-036 Bench SHALL assert ap_rst after 7 of 16 beats, then send 16 beats of 1, and check that the single result is dout=16.
REQ-037 Bench SHALL toggle din_vld randomly (50%) across 16 beats of 1, and check dout=16 with gap cycles not counted.

Source files
------------

// File: rtl/case_1_acc_pkg.sv
// Shared types and default sizing for the streaming product accumulator.
package case_1_acc_pkg;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam int DIN_WIDTH_DEF = 2;
    localparam int ACC_WIDTH_DEF = 8;
    localparam int LEN_DEF       = 16;
    localparam int CNT_WIDTH_DEF = $clog2(LEN_DEF + 1);

    // The counter must be able to hold LEN itself, not just LEN-1.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/case_1_acc_stream.sv
// Sums LEN signed products from the upstream multiplier and presents each sum
// with a valid/ready handshake and a sticky overflow flag.
//
// state | meaning
// S_ACC | collecting products, din_rdy high
// S_OUT | presenting the completed sum, waiting for dout_rdy
module case_1_acc_stream
    import case_1_acc_pkg::*;
#(
    parameter int DIN_WIDTH = DIN_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int LEN       = LEN_DEF
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 din_vld,
    output logic                 din_rdy,
    output logic [ACC_WIDTH-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 dout_ovf
);

    localparam int CNT_WIDTH = cnt_width(LEN);
    localparam int MSB       = ACC_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LEN - 1);

    state_t state, state_nxt;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] din_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [CNT_WIDTH-1:0]        cnt;
    logic                        ovf;
    logic                        beat;
    logic                        take;
    logic                        add_ovf;

    assign din_ext = ACC_WIDTH'($signed(din));
    assign sum     = acc + din_ext;
    assign add_ovf = (acc[MSB] == din_ext[MSB]) && (sum[MSB] != acc[MSB]);

    assign beat = din_vld & din_rdy;
    assign take = dout_vld & dout_rdy;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        din_rdy   = 1'b0;
        dout_vld  = 1'b0;
        case (state)
            S_ACC: begin
                din_rdy = 1'b1;
                if (din_vld && (cnt == CNT_LAST)) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                dout_vld = 1'b1;
                if (dout_rdy) begin
                    state_nxt = S_ACC;
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    // The accumulator doubles as the result register; it is frozen in S_OUT
    // because din_rdy is low there.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (take) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            if (add_ovf) begin
                ovf <= 1'b1;
            end
        end
    end

    assign dout     = acc;
    assign dout_ovf = ovf;

endmodule

// File: tb/tb_case_1_acc_stream.sv
// Randomized directed bench for the product accumulator: a wide LEN=16 instance
// and a narrow LEN=4 / 2-bit instance checked against an arithmetic model.
module tb_case_1_acc_stream;

    logic       ap_clk = 1'b0;
    logic       ap_rst;

    logic [1:0] din_a, din_b;
    logic       din_vld_a, din_vld_b;
    logic       din_rdy_a, din_rdy_b;
    logic [7:0] dout_a;
    logic [1:0] dout_b;
    logic       dout_vld_a, dout_vld_b;
    logic       dout_rdy_a, dout_rdy_b;
    logic       dout_ovf_a, dout_ovf_b;

    int checks = 0;
    int errors = 0;
    int pat[16];

    case_1_acc_stream #(.DIN_WIDTH(2), .ACC_WIDTH(8), .LEN(16)) dut_a (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .din      (din_a),
        .din_vld  (din_vld_a),
        .din_rdy  (din_rdy_a),
        .dout     (dout_a),
        .dout_vld (dout_vld_a),
        .dout_rdy (dout_rdy_a),
        .dout_ovf (dout_ovf_a)
    );

    case_1_acc_stream #(.DIN_WIDTH(2), .ACC_WIDTH(2), .LEN(4)) dut_b (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .din      (din_b),
        .din_vld  (din_vld_b),
        .din_rdy  (din_rdy_b),
        .dout     (dout_b),
        .dout_vld (dout_vld_b),
        .dout_rdy (dout_rdy_b),
        .dout_ovf (dout_ovf_b)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int get_dout(input int inst);
        if (inst == 0) return int'($signed(dout_a));
        return int'($signed(dout_b));
    endfunction

    function automatic int get_vld(input int inst);
        return (inst == 0) ? int'(dout_vld_a) : int'(dout_vld_b);
    endfunction

    function automatic int get_ovf(input int inst);
        return (inst == 0) ? int'(dout_ovf_a) : int'(dout_ovf_b);
    endfunction

    function automatic int get_rdy(input int inst);
        return (inst == 0) ? int'(din_rdy_a) : int'(din_rdy_b);
    endfunction

    // Map any integer onto the signed range of an aw-bit word.
    function automatic int wrap(input int v, input int aw);
        int m;
        int lo;
        int r;
        m  = 1 << aw;
        lo = -(m / 2);
        r  = (v - lo) % m;
        if (r < 0) r += m;
        return r + lo;
    endfunction

    task automatic drive(input int inst, input bit vld, input int d);
        if (inst == 0) begin
            din_vld_a = vld;
            din_a     = 2'(d);
        end else begin
            din_vld_b = vld;
            din_b     = 2'(d);
        end
    endtask

    task automatic set_rdy(input int inst, input bit r);
        if (inst == 0) dout_rdy_a = r;
        else           dout_rdy_b = r;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 16; i++) pat[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 16; i++) pat[i] = int'($urandom_range(0, 3)) - 2;
    endtask

    // Offer nbeats values from pat[] with the given valid probability, then
    // check the presented result, optionally stall for hold cycles and consume.
    task automatic run_group(input int inst, input int nbeats, input int pct,
                             input int hold, input bit consume, input string tag);
        int len;
        int aw;
        int exp_sum;
        int exp_ovf;
        int acc_n;
        int budget;
        int early_vld;
        int w;
        int held;
        int held_ovf;
        len       = (inst == 0) ? 16 : 4;
        aw        = (inst == 0) ? 8 : 2;
        exp_sum   = 0;
        exp_ovf   = 0;
        acc_n     = 0;
        budget    = 0;
        early_vld = 0;
        while (acc_n < nbeats && budget < 1000) begin
            @(negedge ap_clk);
            budget++;
            if (get_vld(inst) != 0) early_vld++;
            set_rdy(inst, 1'($urandom_range(0, 1)));
            if (int'($urandom_range(0, 99)) < pct) begin
                drive(inst, 1'b1, pat[acc_n]);
                if (get_rdy(inst) != 0) begin
                    w = exp_sum + pat[acc_n];
                    if (w != wrap(w, aw)) exp_ovf = 1;
                    exp_sum = wrap(w, aw);
                    acc_n++;
                end
            end else begin
                drive(inst, 1'b0, int'($urandom_range(0, 3)));
            end
        end
        check({tag, " beats_accepted"}, acc_n, nbeats);
        check({tag, " early_dout_vld"}, early_vld, 0);
        if (nbeats < len) return;

        @(negedge ap_clk);
        drive(inst, 1'b0, 0);
        set_rdy(inst, (hold == 0) && consume);
        check({tag, " dout_vld"}, get_vld(inst), 1);
        check({tag, " dout"}, get_dout(inst), exp_sum);
        check({tag, " dout_ovf"}, get_ovf(inst), exp_ovf);
        check({tag, " din_rdy_out"}, get_rdy(inst), 0);
        held     = get_dout(inst);
        held_ovf = get_ovf(inst);

        for (int k = 0; k < hold; k++) begin
            @(negedge ap_clk);
            check({tag, " hold_dout"}, get_dout(inst), exp_sum);
            check({tag, " hold_ovf"}, get_ovf(inst), exp_ovf);
            check({tag, " hold_vld"}, get_vld(inst), 1);
            check({tag, " hold_din_rdy"}, get_rdy(inst), 0);
            drive(inst, 1'b1, -2);
            set_rdy(inst, (k == hold - 1) && consume);
        end
        if (!consume) return;

        @(negedge ap_clk);
        drive(inst, 1'b0, 0);
        check({tag, " vld_after_take"}, get_vld(inst), 0);
        check({tag, " din_rdy_after_take"}, get_rdy(inst), 1);
        check({tag, " dout_cleared"}, get_dout(inst), 0);
        check({tag, " ovf_cleared"}, get_ovf(inst), 0);
        if (held != exp_sum || held_ovf != exp_ovf) return;
    endtask

    initial begin
        int vld_seen;
        ap_rst = 1'b1;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        set_rdy(0, 1'b1);
        set_rdy(1, 1'b1);
        repeat (2) @(negedge ap_clk);
        check("rst dout_a", get_dout(0), 0);
        check("rst vld_a", get_vld(0), 0);
        check("rst ovf_a", get_ovf(0), 0);
        check("rst din_rdy_a", get_rdy(0), 1);
        check("rst dout_b", get_dout(1), 0);
        check("rst vld_b", get_vld(1), 0);
        check("rst ovf_b", get_ovf(1), 0);
        check("rst din_rdy_b", get_rdy(1), 1);
        ap_rst = 1'b0;

        fill_const(1);
        run_group(0, 16, 100, 0, 1'b1, "ones");
        fill_const(-2);
        run_group(0, 16, 100, 0, 1'b1, "neg2");

        pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0;
        run_group(1, 4, 100, 0, 1'b1, "wrap_b");
        fill_const(0);
        run_group(1, 4, 100, 0, 1'b1, "zeros_b");

        fill_rand();
        run_group(0, 16, 100, 5, 1'b1, "hold");
        fill_const(1);
        run_group(0, 16, 100, 0, 1'b1, "after_hold");

        fill_const(1);
        run_group(0, 7, 100, 0, 1'b1, "partial");
        @(negedge ap_clk);
        drive(0, 1'b0, 0);
        ap_rst = 1'b1;
        #1;
        check("midrst dout", get_dout(0), 0);
        check("midrst din_rdy", get_rdy(0), 1);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        vld_seen = 0;
        repeat (20) begin
            @(negedge ap_clk);
            if (get_vld(0) != 0) vld_seen++;
        end
        check("midrst no_result", vld_seen, 0);
        fill_const(1);
        run_group(0, 16, 100, 0, 1'b1, "post_reset");

        fill_rand();
        run_group(0, 16, 100, 0, 1'b0, "pending");
        @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        check("outrst vld", get_vld(0), 0);
        check("outrst dout", get_dout(0), 0);
        check("outrst ovf", get_ovf(0), 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("outrst vld_after", get_vld(0), 0);
        check("outrst din_rdy_after", get_rdy(0), 1);

        fill_const(1);
        run_group(0, 16, 50, 0, 1'b1, "gappy");

        for (int g = 0; g < 3; g++) begin
            fill_rand();
            run_group(0, 16, 60, g, 1'b1, "rand_a");
            fill_rand();
            run_group(1, 4, 60, g, 1'b1, "rand_b");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
